// File: rtl/traffic_light_monitor_if.sv
// Lamp bus between the traffic light controller and the safety monitor,
// plus the monitor's status and fail-safe lamp drive.
interface traffic_light_monitor_if;
    logic [2:0] NS_light;
    logic [2:0] EW_light;
    logic       fault_clr;
    logic       locked;
    logic [1:0] phase;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] cycles;
    logic [2:0] safe_NS_light;
    logic [2:0] safe_EW_light;

    modport master (
        output NS_light, EW_light, fault_clr,
        input  locked, phase, fault, fault_code, cycles, safe_NS_light, safe_EW_light
    );

    modport slave (
        input  NS_light, EW_light, fault_clr,
        output locked, phase, fault, fault_code, cycles, safe_NS_light, safe_EW_light
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// Independent safety monitor for a four-phase traffic light controller:
// tracks phase order and dwell, latches coded faults, flashes red on fault.
module traffic_light_monitor #(
    parameter int PHASE_LEN  = 16,
    parameter int CNT_W      = 8,
    parameter int FLASH_HALF = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    traffic_light_monitor_if.slave  bus
);
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] DARK   = 3'b000;
    localparam int FW = $clog2(2 * FLASH_HALF) + 1;
    localparam logic [CNT_W-1:0] LEN       = CNT_W'(PHASE_LEN);
    localparam logic [FW-1:0]    FLASH_END = FW'(2 * FLASH_HALF - 1);
    localparam logic [FW-1:0]    FLASH_H   = FW'(FLASH_HALF);

    typedef enum logic [1:0] {S_SYNC, S_TRACK, S_FAULT} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_dwell;
    logic [FW-1:0]    r_flash_cnt;
    logic             r_locked;
    logic [1:0]       r_phase;
    logic             r_fault;
    logic [2:0]       r_fault_code;
    logic [7:0]       r_cycles;
    logic [2:0]       r_safe_ns;
    logic [2:0]       r_safe_ew;

    logic             w_ns_oh;
    logic             w_ew_oh;
    logic [1:0]       w_phase;
    logic [2:0]       w_fault_code;
    logic [FW-1:0]    w_flash_nxt;

    assign w_ns_oh = $onehot(bus.NS_light);
    assign w_ew_oh = $onehot(bus.EW_light);

    // Only meaningful for a legal sample: exactly one side is red.
    always_comb begin
        w_phase = 2'd0;
        if (bus.NS_light == RED)
            w_phase = (bus.EW_light == GREEN) ? 2'd2 : 2'd3;
        else
            w_phase = (bus.NS_light == GREEN) ? 2'd0 : 2'd1;
    end

    // Priority chain gives the required 1 > 2 > ... > 6 fault precedence.
    always_comb begin
        w_fault_code = '0;
        if (r_state != S_FAULT) begin
            if (!w_ns_oh || !w_ew_oh)
                w_fault_code = 3'd1;
            else if (bus.NS_light != RED && bus.EW_light != RED)
                w_fault_code = 3'd2;
            else if (bus.NS_light == RED && bus.EW_light == RED)
                w_fault_code = 3'd3;
            else if (w_phase != r_phase) begin
                if (w_phase != r_phase + 2'd1)
                    w_fault_code = 3'd4;
                else if (r_state == S_TRACK && r_dwell < LEN)
                    w_fault_code = 3'd5;
            end else if (r_state == S_TRACK && r_dwell == LEN)
                w_fault_code = 3'd6;
        end
    end

    assign w_flash_nxt = (r_flash_cnt == FLASH_END) ? '0 : r_flash_cnt + FW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_SYNC;
            r_dwell      <= '0;
            r_flash_cnt  <= '0;
            r_locked     <= 1'b0;
            r_phase      <= 2'd0;
            r_fault      <= 1'b0;
            r_fault_code <= '0;
            r_cycles     <= '0;
            r_safe_ns    <= RED;
            r_safe_ew    <= RED;
        end else if (bus.fault_clr) begin
            r_state      <= S_SYNC;
            r_dwell      <= '0;
            r_locked     <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= '0;
            r_safe_ns    <= bus.NS_light;
            r_safe_ew    <= bus.EW_light;
        end else if (w_fault_code != 3'd0) begin
            r_state      <= S_FAULT;
            r_fault      <= 1'b1;
            r_fault_code <= w_fault_code;
            r_locked     <= 1'b0;
            r_flash_cnt  <= '0;
            r_safe_ns    <= RED;
            r_safe_ew    <= RED;
        end else begin
            case (r_state)
                S_SYNC: begin
                    r_safe_ns <= bus.NS_light;
                    r_safe_ew <= bus.EW_light;
                    if (w_phase != r_phase) begin
                        r_state  <= S_TRACK;
                        r_locked <= 1'b1;
                        r_dwell  <= CNT_W'(1);
                        r_phase  <= w_phase;
                    end
                end
                S_TRACK: begin
                    r_safe_ns <= bus.NS_light;
                    r_safe_ew <= bus.EW_light;
                    if (w_phase == r_phase)
                        r_dwell <= r_dwell + CNT_W'(1);
                    else begin
                        r_dwell <= CNT_W'(1);
                        r_phase <= w_phase;
                        if (r_phase == 2'd3)
                            r_cycles <= r_cycles + 8'd1;
                    end
                end
                default: begin
                    r_flash_cnt <= w_flash_nxt;
                    r_safe_ns   <= (w_flash_nxt < FLASH_H) ? RED : DARK;
                    r_safe_ew   <= (w_flash_nxt < FLASH_H) ? RED : DARK;
                end
            endcase
        end
    end

    assign bus.locked        = r_locked;
    assign bus.phase         = r_phase;
    assign bus.fault         = r_fault;
    assign bus.fault_code    = r_fault_code;
    assign bus.cycles        = r_cycles;
    assign bus.safe_NS_light = r_safe_ns;
    assign bus.safe_EW_light = r_safe_ew;
endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Safety monitor that sits on the receiving end of the traffic light controller's lamp bus. It samples the NS/EW lamp codes every clock, locks onto the four-phase sequence, and checks encoding, phase order and phase dwell time. On any violation it latches a coded fault and forces the downstream lamp drivers to flashing red. It drives the physical lamp drivers in place of the controller, giving the intersection an independent fail-safe layer.

## Interface
- PHASE_LEN, 16: required dwell of every phase in clock cycles; legal range 2 to 2^CNT_W-1.
- CNT_W, 8: width of the dwell counter.
- FLASH_HALF, 8: half-period of the fault flash in clock cycles; must be 1 or more.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- NS_light  in  3  observed NS lamp code: RED=100, YELLOW=010, GREEN=001.
- EW_light  in  3  observed EW lamp code, same encoding.
- fault_clr  in  1  synchronous clear of a latched fault; returns the monitor to SYNC.
- locked  out  1  high while in TRACK.
- phase  out  2  last legal phase sampled: P0=(G,R), P1=(Y,R), P2=(R,G), P3=(R,Y).
- fault  out  1  sticky fault flag.
- fault_code  out  3  0 none, 1 non-one-hot, 2 conflict, 3 all-red, 4 bad sequence, 5 short phase, 6 long phase.
- cycles  out  8  count of completed P3->P0 transitions in TRACK; wraps 255->0.
- safe_NS_light  out  3  lamp drive for NS.
- safe_EW_light  out  3  lamp drive for EW.

## Operation
- Classification of each sample:
  - Code 1: either input is not one-hot.
  - Code 2: both inputs are one-hot and both are non-red.
  - Code 3: both inputs are RED.
  - Otherwise the sample is a legal phase P0..P3.
- Successor order is P0->P1->P2->P3->P0.
- The FSM has three states: SYNC, TRACK, FAULT. Reset enters SYNC.
- SYNC:
  - An illegal sample (code 1-3) goes to FAULT.
  - A phase change to the successor goes to TRACK with dwell=1.
  - A phase change to a non-successor goes to FAULT with code 4.
  - No dwell checks are made in SYNC, because the monitor may start mid-phase.
- TRACK:
  - Same phase as the previous sample: if dwell==PHASE_LEN, go to FAULT with code 6; otherwise dwell+1.
  - Phase change: if dwell<PHASE_LEN, code 5. If the new phase is not the successor, code 4. If the successor arrives with dwell==PHASE_LEN, dwell=1.
  - A legal P3->P0 change increments cycles.
- Fault precedence when several conditions hit on one sample: 1 > 2 > 3 > 4 > 5 > 6.
- FAULT:
  - fault=1 and fault_code are held. locked=0. phase and cycles freeze.
  - Only fault_clr or reset leave this state.
- fault_clr:
  - Sampled high in any state: go to SYNC, fault=0, fault_code=0, locked=0. cycles is kept.
  - The sample taken in the same cycle is discarded; fault_clr beats a simultaneous new fault.
- Safe lamp outputs:
  - Outside FAULT: registered copies of NS_light and EW_light.
  - In FAULT: both lamps show RED for FLASH_HALF cycles, then 000 for FLASH_HALF cycles, repeating. The RED half starts on the first FAULT cycle.

## Timing
- Reset values: locked=0, phase=0, fault=0, fault_code=0, cycles=0, safe_NS_light=100, safe_EW_light=100, FSM=SYNC, dwell=0, flash counter=0.
- All outputs are registered. Each takes effect one clock after the edge that sampled the causing input.
- Safe lamps pass inputs through with 1-cycle latency outside FAULT.
- Flash behaviour:
  - The first flash RED appears in the same cycle fault rises.
  - The flash counter restarts on every FAULT entry.
- Reset asserted mid-operation forces the reset values immediately, with no clock needed.
- With a nominal controller (PHASE_LEN=16), each phase occupies exactly 16 consecutive samples, and one full cycle is 64 clocks.

## Test plan
- Nominal sequence, PHASE_LEN=16:
  - Stimulus: reset, then drive P0..P3 at 16 cycles each for 3 full rotations.
  - Response: locked=1 one clock after the first P1 sample. fault stays 0 throughout. cycles=2 after the final P3->P0.
- Short phase:
  - Stimulus: after lock, hold P1 for 15 samples, then drive P2.
  - Response: one clock after the P2 sample, fault=1 and code=5. Safe lamps show 100/100 for 8 cycles, then 000/000 for 8 cycles.
- Long phase:
  - Stimulus: after lock, hold P2 for 17 samples.
  - Response: code 6 one clock after the 17th sample; phase frozen at 2.
- Encoding faults:
  - NS=001, EW=001 gives code 2.
  - NS=011, EW=100 gives code 1.
  - 100/100 gives code 3.
  - In every case fault rises one clock later, including from SYNC.
- Sequence skip:
  - Stimulus: after lock, hold P0 for exactly 16 samples, then drive P2.
  - Response: code 4, not 5.
- Clear and reset:
  - fault_clr in FAULT gives fault=0, locked=0 next clock, and cycles is retained; relock then follows the normal SYNC rules.
  - fault_clr coincident with a conflict sample leaves fault=0.
  - Async reset mid-P1 clears all outputs to reset values before the next clock edge.
